// File: rtl/conv_peak_pkg.sv
// conv_peak_pkg: shared types and constants for the convolve/peak engine.
//   fsm_t        engine sequencing states
//   CTRL_*       bit positions inside the CTRL register
//   *_BASE/REG_* word addresses of the register block and memory windows
//   acc_width()  accumulator width needed for a symmetric kernel of KHALF taps
package conv_peak_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } fsm_t;

  // CTRL bit positions (write view; read view reuses bits 1 and 3).
  localparam int CTRL_START    = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_CLR_DONE = 2;
  localparam int CTRL_FIND_MIN = 3;
  // CTRL read-only status positions.
  localparam int CTRL_BUSY     = 0;
  localparam int CTRL_DONE     = 2;

  // Region bases (word addresses).
  localparam logic [31:0] REG_BASE    = 32'h000;
  localparam logic [31:0] SAMPLE_BASE = 32'h100;
  localparam logic [31:0] KERNEL_BASE = 32'h200;
  localparam logic [31:0] RESULT_BASE = 32'h300;

  // Register offsets inside the register block.
  localparam logic [31:0] REG_CTRL   = REG_BASE + 32'd0;
  localparam logic [31:0] REG_VAL    = REG_BASE + 32'd1;
  localparam logic [31:0] REG_POS    = REG_BASE + 32'd2;
  localparam logic [31:0] REG_PARAMS = REG_BASE + 32'd3;

  // 8b x 8b products summed over K = 2*KHALF-1 taps never overflow this width.
  function automatic int acc_width(input int khalf);
    return 16 + $clog2(2 * khalf - 1);
  endfunction

endpackage

// File: rtl/conv_peak_mac.sv
// conv_peak_mac: sequential single-MAC convolution engine with best tracker.
//   clk, reset_n        clock, asynchronous active-low reset
//   start               one-cycle request to begin a run (ignored while busy)
//   find_min            mode for the run being started (1 = track minimum)
//   sample, coef        RAM data addressed by samp_idx / coef_idx this cycle
//   res_we/addr/data    write port for the per-position result RAM
//   busy                high from the start edge through the DONE cycle
//   finish              high during the single DONE cycle
//   result_val/pos      best response and its centre index from the last run
module conv_peak_mac
  import conv_peak_pkg::*;
#(
  parameter int N_SAMPLES = 48,
  parameter int KHALF     = 8,
  localparam int ACC_W    = acc_width(KHALF),
  localparam int IW       = $clog2(N_SAMPLES + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             find_min,
  input  logic [7:0]       sample,
  input  logic [7:0]       coef,
  output logic [IW-1:0]    samp_idx,
  output logic [IW-1:0]    coef_idx,
  output logic             res_we,
  output logic [IW-1:0]    res_addr,
  output logic [ACC_W-1:0] res_data,
  output logic             busy,
  output logic             finish,
  output logic [ACC_W-1:0] result_val,
  output logic [IW-1:0]    result_pos
);

  localparam int K    = 2 * KHALF - 1;
  localparam int NPOS = N_SAMPLES - K + 1;
  localparam logic [IW-1:0] KH_I  = IW'(KHALF);
  localparam logic [IW-1:0] KM1_I = IW'(K - 1);
  localparam logic [IW-1:0] NPM1  = IW'(NPOS - 1);

  fsm_t             state;
  logic [IW-1:0]    j;
  logic [IW-1:0]    p;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] best;
  logic [IW-1:0]    best_pos;
  logic             min_mode;

  logic [15:0]      prod;
  logic [ACC_W-1:0] sum;
  logic             last_tap;
  logic             better;

  // Symmetric kernel: taps mirror around the centre tap KHALF-1.
  assign samp_idx = p + j;
  assign coef_idx = (j < KH_I) ? j : (KM1_I - j);

  assign prod     = {8'h00, sample} * {8'h00, coef};
  // Tap 0 restarts the sum, so the accumulator never needs clearing.
  assign sum      = ((j == '0) ? '0 : acc) + ACC_W'(prod);
  assign last_tap = (j == KM1_I);
  // Strict compare keeps the earliest position on ties.
  assign better   = min_mode ? (sum < best) : (sum > best);

  assign res_we   = (state == S_RUN) && last_tap;
  assign res_addr = p;
  assign res_data = sum;
  assign finish   = (state == S_DONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the async reset sits in the sensitivity list.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      j          <= '0;
      p          <= '0;
      acc        <= '0;
      best       <= '0;
      best_pos   <= '0;
      min_mode   <= 1'b0;
      result_val <= '0;
      result_pos <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_RUN;
            busy     <= 1'b1;
            j        <= '0;
            p        <= '0;
            min_mode <= find_min;
          end
        end
        S_RUN: begin
          if (last_tap) begin
            j <= '0;
            if ((p == '0) || better) begin
              best     <= sum;
              best_pos <= p + KH_I - IW'(1);
            end
            if (p == NPM1) state <= S_DONE;
            else           p     <= p + IW'(1);
          end else begin
            j   <= j + IW'(1);
            acc <= sum;
          end
        end
        S_DONE: begin
          result_val <= best;
          result_pos <= best_pos;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/conv_peak_engine.sv
// conv_peak_engine: Avalon-MM slave wrapping the convolve/peak MAC engine.
//   clk, reset_n         clock, asynchronous active-low reset
//   address/read/write   word-addressed slave access, zero wait states
//   byteenable/writedata write lanes and data (CTRL uses lane 0)
//   readdata/valid       registered read data, valid one cycle after read
//   waitrequest          always 0
//   irq                  done & irq_en
// Holds the CTRL register, sample/kernel/result memories and bus decode.
module conv_peak_engine
  import conv_peak_pkg::*;
#(
  parameter int N_SAMPLES = 48,
  parameter int KHALF     = 8,
  parameter int ADDR_W    = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [3:0]        byteenable,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              readdatavalid,
  output logic              waitrequest,
  output logic              irq
);

  localparam int K      = 2 * KHALF - 1;
  localparam int NPOS   = N_SAMPLES - K + 1;
  localparam int ACC_W  = acc_width(KHALF);
  localparam int IW     = $clog2(N_SAMPLES + 1);
  localparam int SWORDS = N_SAMPLES / 4;
  localparam int KWORDS = (KHALF + 3) / 4;
  localparam int KBYTES = 4 * KWORDS;
  localparam int RDEPTH = (NPOS < 2) ? 2 : NPOS;
  localparam int SIDX_W = $clog2(N_SAMPLES);
  localparam int KIDX_W = $clog2(KBYTES);
  localparam int RIDX_W = $clog2(RDEPTH);

  logic [7:0]       s_mem [N_SAMPLES];
  logic [7:0]       g_mem [KBYTES];
  logic [ACC_W-1:0] r_mem [RDEPTH];

  logic [31:0] a32, woff_s, woff_k, woff_r, rd_mux;
  logic        hit_samp, hit_kern, hit_res, ctrl_wr, start;
  logic        irq_en, find_min, done;

  logic [IW-1:0]    samp_idx, coef_idx, res_addr, result_pos;
  logic [ACC_W-1:0] res_data, result_val;
  logic             res_we, busy, finish;

  assign waitrequest = 1'b0;
  assign irq         = done & irq_en;

  assign a32      = 32'(address);
  assign woff_s   = a32 - SAMPLE_BASE;
  assign woff_k   = a32 - KERNEL_BASE;
  assign woff_r   = a32 - RESULT_BASE;
  assign hit_samp = (a32 >= SAMPLE_BASE) && (a32 < SAMPLE_BASE + 32'(SWORDS));
  assign hit_kern = (a32 >= KERNEL_BASE) && (a32 < KERNEL_BASE + 32'(KWORDS));
  assign hit_res  = (a32 >= RESULT_BASE) && (a32 < RESULT_BASE + 32'(NPOS));

  assign ctrl_wr  = write && (a32 == REG_CTRL) && byteenable[0];
  assign start    = ctrl_wr && writedata[CTRL_START] && !busy;

  conv_peak_mac #(.N_SAMPLES(N_SAMPLES), .KHALF(KHALF)) u_mac (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .find_min   (writedata[CTRL_FIND_MIN]),
    .sample     (s_mem[SIDX_W'(samp_idx)]),
    .coef       (g_mem[KIDX_W'(coef_idx)]),
    .samp_idx   (samp_idx),
    .coef_idx   (coef_idx),
    .res_we     (res_we),
    .res_addr   (res_addr),
    .res_data   (res_data),
    .busy       (busy),
    .finish     (finish),
    .result_val (result_val),
    .result_pos (result_pos)
  );

  // CTRL: irq_en/find_min follow every CTRL write; a new start clears done
  // even if clear_done is written alongside it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en   <= 1'b0;
      find_min <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        irq_en   <= writedata[CTRL_IRQ_EN];
        find_min <= writedata[CTRL_FIND_MIN];
      end
      if (finish)                                   done <= 1'b1;
      else if (start)                               done <= 1'b0;
      else if (ctrl_wr && writedata[CTRL_CLR_DONE]) done <= 1'b0;
    end
  end

  // NOTE: the memories have no reset branch on purpose; clearing them would
  // cost a reset fan-out per bit and software always reloads them anyway.
  always_ff @(posedge clk) begin
    if (write && !busy && hit_samp) begin
      for (int k = 0; k < 4; k++)
        if (byteenable[k]) s_mem[SIDX_W'(woff_s * 4 + k)] <= writedata[8*k +: 8];
    end
    if (write && !busy && hit_kern) begin
      for (int k = 0; k < 4; k++)
        if (byteenable[k]) g_mem[KIDX_W'(woff_k * 4 + k)] <= writedata[8*k +: 8];
    end
    if (res_we) r_mem[RIDX_W'(res_addr)] <= res_data;
  end

  // NOTE: rd_mux gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_mux = '0;
    if (a32 == REG_CTRL) begin
      rd_mux[CTRL_BUSY]     = busy;
      rd_mux[CTRL_IRQ_EN]   = irq_en;
      rd_mux[CTRL_DONE]     = done;
      rd_mux[CTRL_FIND_MIN] = find_min;
    end else if (a32 == REG_VAL) begin
      rd_mux = 32'(result_val);
    end else if (a32 == REG_POS) begin
      rd_mux = 32'(result_pos);
    end else if (a32 == REG_PARAMS) begin
      rd_mux = {8'h00, 8'(KHALF), 16'(N_SAMPLES)};
    end else if (hit_samp) begin
      for (int k = 0; k < 4; k++) rd_mux[8*k +: 8] = s_mem[SIDX_W'(woff_s * 4 + k)];
    end else if (hit_kern) begin
      for (int k = 0; k < 4; k++) rd_mux[8*k +: 8] = g_mem[KIDX_W'(woff_k * 4 + k)];
    end else if (hit_res) begin
      rd_mux = 32'(r_mem[RIDX_W'(woff_r)]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= read;
      if (read) readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_conv_peak_engine.sv
// tb_conv_peak_engine: directed bench for conv_peak_engine (N=48, KHALF=8).
// Reads push their expected word into a queue; a monitor pops on
// readdatavalid and compares data and the one-cycle read latency.
module tb_conv_peak_engine;

  localparam int LAT = 34 * 15 + 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [3:0]  byteenable = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        readdatavalid, waitrequest, irq;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] exp;
    int          due;
    string       name;
  } rd_t;
  rd_t q[$];

  conv_peak_engine #(.N_SAMPLES(48), .KHALF(8), .ADDR_W(11)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .address       (address),
    .read          (read),
    .write         (write),
    .byteenable    (byteenable),
    .writedata     (writedata),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .waitrequest   (waitrequest),
    .irq           (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    rd_t t;
    if (reset_n) begin
      if (readdatavalid) begin
        if (q.size() == 0) begin
          check("spurious_rdv", 32'(readdatavalid), 32'd0);
        end else begin
          t = q.pop_front();
          check(t.name, readdata, t.exp);
          check({t.name, "_lat"}, 32'(cyc), 32'(t.due));
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        t = q.pop_front();
        check({t.name, "_rdv"}, 32'(readdatavalid), 32'd1);
      end
    end
  end

  task automatic bus_write(input logic [10:0] a, input logic [31:0] d,
                           input logic [3:0] be, output int e);
    @(negedge clk);
    address = a; writedata = d; byteenable = be; write = 1'b1;
    @(negedge clk);
    write = 1'b0; byteenable = '0;
    e = cyc;  // edge that sampled the write
  endtask

  task automatic wr(input logic [10:0] a, input logic [31:0] d);
    int e;
    bus_write(a, d, 4'hF, e);
  endtask

  task automatic bus_read(input logic [10:0] a, input logic [31:0] exp, input string name);
    @(negedge clk);
    address = a; read = 1'b1;
    q.push_back('{exp: exp, due: cyc + 1, name: name});
    @(negedge clk);
    read = 1'b0;
  endtask

  task automatic wait_done(input int e, input string name);
    int n = 0;
    while (!irq && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!irq) check({name, "_timeout"}, 32'(irq), 32'd1);
    else      check(name, 32'(cyc - e), 32'(LAT));
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", 32'(q.size()), 32'd0);
  endtask

  task automatic load_ramp();
    for (int w = 0; w < 12; w++)
      wr(11'(32'h100 + w), {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
  endtask

  initial begin
    int e;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Reset state and read-only registers.
    bus_read(11'h000, 32'h0, "rst_ctrl");
    bus_read(11'h001, 32'h0, "rst_val");
    bus_read(11'h002, 32'h0, "rst_pos");
    bus_read(11'h003, 32'h0008_0030, "params");
    check("rst_irq", 32'(irq), 32'd0);

    // Clear memories, then byte-lane write to a zeroed sample word.
    for (int w = 0; w < 12; w++) wr(11'(32'h100 + w), 32'h0);
    wr(11'h200, 32'h0);
    wr(11'h201, 32'h0);
    bus_write(11'h10A, 32'h1122_3344, 4'b0101, e);
    bus_read(11'h10A, 32'h0022_0044, "byte_lanes");
    wr(11'h10A, 32'h0);

    // Impulse: s[20]=100, centre tap g[7]=1.
    wr(11'h105, 32'h0000_0064);
    wr(11'h201, 32'h0100_0000);
    bus_read(11'h201, 32'h0100_0000, "kern_rb");
    bus_write(11'h000, 32'h3, 4'hF, e);
    wait_done(e, "imp_latency");
    bus_read(11'h001, 32'd100, "imp_val");
    bus_read(11'h002, 32'd20, "imp_pos");
    for (int p = 0; p < 34; p++)
      bus_read(11'(32'h300 + p), (p == 13) ? 32'd100 : 32'd0, $sformatf("imp_conv%0d", p));
    bus_read(11'h004, 32'h0, "unmapped_004");
    bus_read(11'h10C, 32'h0, "unmapped_10c");
    bus_read(11'h322, 32'h0, "unmapped_322");

    // Saturating data: all ties, lowest position wins; irq/clear_done.
    for (int w = 0; w < 12; w++) wr(11'(32'h100 + w), 32'hFFFF_FFFF);
    wr(11'h200, 32'hFFFF_FFFF);
    wr(11'h201, 32'hFFFF_FFFF);
    bus_write(11'h000, 32'h3, 4'hF, e);
    wait_done(e, "sat_latency");
    check("sat_irq", 32'(irq), 32'd1);
    bus_read(11'h001, 32'd975375, "sat_val");
    bus_read(11'h002, 32'd7, "sat_pos");
    bus_read(11'h300, 32'd975375, "sat_conv0");
    bus_read(11'h321, 32'd975375, "sat_conv33");
    bus_read(11'h000, 32'h6, "sat_ctrl");
    wr(11'h000, 32'h6);
    @(negedge clk);
    check("sat_irq_clr", 32'(irq), 32'd0);

    // Min mode on a ramp with unit kernel: conv[p] = 15p + 105.
    load_ramp();
    wr(11'h200, 32'h0101_0101);
    wr(11'h201, 32'h0101_0101);
    bus_write(11'h000, 32'hB, 4'hF, e);
    wait_done(e, "min_latency");
    bus_read(11'h001, 32'd105, "min_val");
    bus_read(11'h002, 32'd7, "min_pos");
    bus_read(11'h321, 32'd600, "min_conv33");
    bus_read(11'h000, 32'hE, "min_ctrl");

    // Busy protection: sample write and second start dropped mid-run.
    bus_write(11'h000, 32'h3, 4'hF, e);
    begin
      int e2;
      while (cyc < e + 4) @(negedge clk);
      bus_write(11'h100, 32'hFFFF_FFFF, 4'hF, e2);
      bus_write(11'h000, 32'h3, 4'hF, e2);
    end
    bus_read(11'h001, 32'd105, "busy_prev_val");
    bus_read(11'h002, 32'd7, "busy_prev_pos");
    bus_read(11'h000, 32'h3, "busy_ctrl");
    wait_done(e, "busy_latency");
    bus_read(11'h100, 32'h0302_0100, "busy_samp_kept");
    bus_read(11'h001, 32'd600, "busy_val");
    bus_read(11'h002, 32'd40, "busy_pos");
    bus_read(11'h300, 32'd105, "busy_conv0");
    drain();

    // Reset mid-run, then restart.
    bus_write(11'h000, 32'h3, 4'hF, e);
    while (cyc < e + 199) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_mid_irq", 32'(irq), 32'd0);
    reset_n = 1'b1;
    bus_read(11'h000, 32'h0, "rst_mid_ctrl");
    bus_read(11'h001, 32'h0, "rst_mid_val");
    bus_read(11'h002, 32'h0, "rst_mid_pos");
    bus_write(11'h000, 32'h3, 4'hF, e);
    wait_done(e, "restart_latency");
    bus_read(11'h001, 32'd600, "restart_val");
    bus_read(11'h002, 32'd40, "restart_pos");
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
